// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
//
// Shared definitions for the convolution window driver:
//   - default image/filter geometry and data width
//   - derived widths (product, accumulator, addresses)
//   - FSM state encoding
//
// No ports; imported by conv_addr_gen and conv_window_driver.
// -----------------------------------------------------------------------------
package conv_pkg;

    // Address/counter width helper: never returns 0, so a 1-entry range
    // still gets a 1-bit signal.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Default geometry.
    localparam int IMG_W_DEF = 4;
    localparam int IMG_H_DEF = 4;
    localparam int K_DEF     = 3;
    localparam int DW_DEF    = 4;

    // Product of two DW-bit operands.
    localparam int PW_DEF = 2 * DW_DEF;

    // K*K products of at most (2^DW-1)^2 each stay below K*K * 2^PW, which
    // fits in PW + clog2(K*K) bits; the sum is exact, so no overflow logic.
    localparam int ACC_W_DEF = PW_DEF + clog2_min1(K_DEF * K_DEF);

    // Row-major address widths.
    localparam int IMG_AW_DEF  = clog2_min1(IMG_W_DEF * IMG_H_DEF);
    localparam int FILT_AW_DEF = clog2_min1(K_DEF * K_DEF);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_OUT   = 3'd3,
        ST_DONE  = 3'd4
    } conv_state_e;

endpackage : conv_pkg

// File: rtl/conv_addr_gen.sv
// -----------------------------------------------------------------------------
// conv_addr_gen
//
// Window/tap counters for the convolution walk. (ox, oy) is the window
// origin, (tx, ty) the tap inside the window. Taps advance tx first, then ty;
// windows advance ox first, then oy. Addresses are row-major.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   clear_i      in   force all counters to 0 (held while idle)
//   step_tap_i   in   advance to the next tap (one tap issued this cycle)
//   adv_win_i    in   advance to the next window origin
//   img_addr_o   out  (oy+ty)*IMG_W + (ox+tx)
//   filt_addr_o  out  ty*K + tx
//   last_tap_o   out  current tap is K*K-1
//   last_win_o   out  current window origin is (IMG_W-K, IMG_H-K)
// -----------------------------------------------------------------------------
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int K       = K_DEF,
    parameter int IMG_AW  = clog2_min1(IMG_W * IMG_H),
    parameter int FILT_AW = clog2_min1(K * K)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               step_tap_i,
    input  logic               adv_win_i,
    output logic [IMG_AW-1:0]  img_addr_o,
    output logic [FILT_AW-1:0] filt_addr_o,
    output logic               last_tap_o,
    output logic               last_win_o
);

    localparam int XW = clog2_min1(IMG_W);
    localparam int YW = clog2_min1(IMG_H);
    localparam int KW = clog2_min1(K);

    localparam logic [XW-1:0] OX_MAX = XW'(IMG_W - K);
    localparam logic [YW-1:0] OY_MAX = YW'(IMG_H - K);
    localparam logic [KW-1:0] T_MAX  = KW'(K - 1);

    logic [XW-1:0] ox_q, ox_d;
    logic [YW-1:0] oy_q, oy_d;
    logic [KW-1:0] tx_q, tx_d;
    logic [KW-1:0] ty_q, ty_d;

    assign last_tap_o = (tx_q == T_MAX) && (ty_q == T_MAX);
    assign last_win_o = (ox_q == OX_MAX) && (oy_q == OY_MAX);

    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        ox_d = ox_q;
        oy_d = oy_q;
        tx_d = tx_q;
        ty_d = ty_q;

        if (clear_i) begin
            ox_d = '0;
            oy_d = '0;
            tx_d = '0;
            ty_d = '0;
        end else begin
            // Tap walk wraps back to (0,0) after the last tap, ready for the
            // next window.
            if (step_tap_i) begin
                if (tx_q == T_MAX) begin
                    tx_d = '0;
                    ty_d = (ty_q == T_MAX) ? '0 : ty_q + KW'(1);
                end else begin
                    tx_d = tx_q + KW'(1);
                end
            end

            // Window walk also wraps to (0,0) after the last window so oy
            // never runs past its range.
            if (adv_win_i) begin
                if (ox_q == OX_MAX) begin
                    ox_d = '0;
                    oy_d = (oy_q == OY_MAX) ? '0 : oy_q + YW'(1);
                end else begin
                    ox_d = ox_q + XW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            ox_q <= '0;
            oy_q <= '0;
            tx_q <= '0;
            ty_q <= '0;
        end else begin
            ox_q <= ox_d;
            oy_q <= oy_d;
            tx_q <= tx_d;
            ty_q <= ty_d;
        end
    end

    always_comb begin
        img_addr_o  = (IMG_AW'(oy_q) + IMG_AW'(ty_q)) * IMG_AW'(IMG_W)
                    + IMG_AW'(ox_q) + IMG_AW'(tx_q);
        filt_addr_o = FILT_AW'(ty_q) * FILT_AW'(K) + FILT_AW'(tx_q);
    end

endmodule : conv_addr_gen

// File: rtl/conv_window_driver.sv
// -----------------------------------------------------------------------------
// conv_window_driver
//
// Walks a KxK filter over an IMG_W x IMG_H image (stride 1, no padding),
// feeding one pixel/tap pair per cycle to an external combinational
// multiplier and summing each window's products. Each finished sum leaves on
// a valid/ready stream; out_last marks the final window of the frame.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   go         in   start pulse, only honoured while idle
//   img_addr   out  row-major pixel address
//   img_data   in   pixel at img_addr (same-cycle read)
//   filt_addr  out  row-major tap address
//   filt_data  in   tap at filt_addr (same-cycle read)
//   mul_start  out  multiplier enable, high the cycle after a tap is issued
//   mul_din0   out  registered image operand
//   mul_din1   out  registered filter operand
//   mul_dout   in   multiplier product
//   out_valid  out  convolution result valid
//   out_ready  in   sink accepts result
//   out_data   out  convolution sum
//   out_last   out  final result of the frame
//   busy       out  not idle
//   done       out  one-cycle pulse after the last result is accepted
// -----------------------------------------------------------------------------
module conv_window_driver
    import conv_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int K       = K_DEF,
    parameter int DW      = DW_DEF,
    parameter int PW      = 2 * DW,
    parameter int ACC_W   = PW + clog2_min1(K * K),
    parameter int IMG_AW  = clog2_min1(IMG_W * IMG_H),
    parameter int FILT_AW = clog2_min1(K * K)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    output logic [IMG_AW-1:0]  img_addr,
    input  logic [DW-1:0]      img_data,
    output logic [FILT_AW-1:0] filt_addr,
    input  logic [DW-1:0]      filt_data,
    output logic               mul_start,
    output logic [DW-1:0]      mul_din0,
    output logic [DW-1:0]      mul_din1,
    input  logic [PW-1:0]      mul_dout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_data,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    conv_state_e state_q, state_d;

    logic             mul_start_q, mul_start_d;
    logic [DW-1:0]    mul_din0_q, mul_din0_d;
    logic [DW-1:0]    mul_din1_q, mul_din1_d;
    logic [ACC_W-1:0] acc_q, acc_d;

    // Strobes to the counter block.
    logic issue_tap;
    logic clear_cnt;
    logic handshake;
    logic last_tap;
    logic last_win;

    conv_addr_gen #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .K       (K),
        .IMG_AW  (IMG_AW),
        .FILT_AW (FILT_AW)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear_cnt),
        .step_tap_i  (issue_tap),
        .adv_win_i   (handshake),
        .img_addr_o  (img_addr),
        .filt_addr_o (filt_addr),
        .last_tap_o  (last_tap),
        .last_win_o  (last_win)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (go) state_d = ST_MAC;
            ST_MAC:   if (last_tap) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_OUT;
            ST_OUT:   if (out_ready) state_d = last_win ? ST_DONE : ST_MAC;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        issue_tap = 1'b0;
        clear_cnt = 1'b0;
        handshake = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                clear_cnt = 1'b1;
                busy      = 1'b0;
            end
            ST_MAC: begin
                issue_tap = 1'b1;
            end
            ST_DRAIN: begin
            end
            ST_OUT: begin
                out_valid = 1'b1;
                out_last  = last_win;
                out_data  = acc_q;
                handshake = out_ready;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------ datapath
    // Operands are only registered while a tap is issued; otherwise they are
    // zeroed together with mul_start so the idle multiplier sees 0 x 0.
    // The accumulator adds one cycle behind the issue, so the product of the
    // final tap lands during DRAIN.
    always_comb begin
        mul_start_d = issue_tap;
        mul_din0_d  = issue_tap ? img_data  : '0;
        mul_din1_d  = issue_tap ? filt_data : '0;
        acc_d       = acc_q;
        if (clear_cnt || handshake) begin
            acc_d = '0;
        end else if (mul_start_q) begin
            acc_d = acc_q + ACC_W'(mul_dout);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_start_q <= 1'b0;
            mul_din0_q  <= '0;
            mul_din1_q  <= '0;
            acc_q       <= '0;
        end else begin
            mul_start_q <= mul_start_d;
            mul_din0_q  <= mul_din0_d;
            mul_din1_q  <= mul_din1_d;
            acc_q       <= acc_d;
        end
    end

    assign mul_start = mul_start_q;
    assign mul_din0  = mul_din0_q;
    assign mul_din1  = mul_din1_q;

endmodule : conv_window_driver

// File: tb/tb_conv_window_driver.sv
module tb_conv_window_driver;
    import conv_pkg::*;

    localparam int IMG_AW  = IMG_AW_DEF;
    localparam int FILT_AW = FILT_AW_DEF;
    localparam int DW      = DW_DEF;
    localparam int PW      = PW_DEF;
    localparam int ACC_W   = ACC_W_DEF;

    logic               clk = 1'b0;
    logic               rst;
    logic               go;
    logic [IMG_AW-1:0]  img_addr;
    logic [DW-1:0]      img_data;
    logic [FILT_AW-1:0] filt_addr;
    logic [DW-1:0]      filt_data;
    logic               mul_start;
    logic [DW-1:0]      mul_din0;
    logic [DW-1:0]      mul_din1;
    logic [PW-1:0]      mul_dout;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_data;
    logic               out_last;
    logic               busy;
    logic               done;

    logic [DW-1:0] img_mem  [16];
    logic [DW-1:0] filt_mem [16];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Storage and multiplier models.
    assign img_data  = img_mem[img_addr];
    assign filt_data = filt_mem[filt_addr];
    assign mul_dout  = mul_din0 * mul_din1;

    conv_window_driver dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .img_addr  (img_addr),
        .img_data  (img_data),
        .filt_addr (filt_addr),
        .filt_data (filt_data),
        .mul_start (mul_start),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // pix_mode 0: constant pix_val; 1: pixel i = i. tap_center: only tap 4 = 1.
    task automatic load_mem(input int pix_mode, input int pix_val, input int tap_val,
                            input bit tap_center);
        for (int i = 0; i < 16; i++) begin
            img_mem[i]  = (pix_mode == 1) ? DW'(i) : DW'(pix_val);
            filt_mem[i] = '0;
        end
        for (int i = 0; i < 9; i++) begin
            filt_mem[i] = tap_center ? ((i == 4) ? DW'(1) : DW'(0)) : DW'(tap_val);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_valid"},     out_valid, 0);
        check({tag, "_data"},      out_data, 0);
        check({tag, "_last"},      out_last, 0);
        check({tag, "_done"},      done, 0);
        check({tag, "_mul_start"}, mul_start, 0);
        check({tag, "_din0"},      mul_din0, 0);
        check({tag, "_din1"},      mul_din1, 0);
        check({tag, "_img_addr"},  img_addr, 0);
        check({tag, "_filt_addr"}, filt_addr, 0);
    endtask

    // Runs one frame from a go pulse. Negedge c lies between posedge c-1 and
    // posedge c, where posedge 0 samples go.
    task automatic run_frame(input int e0, input int e1, input int e2, input int e3,
                             input int stall_idx, input int stall_n,
                             input bit inject_go, input int exp_done_c);
        int  exp_v [4];
        int  idx       = 0;
        int  c         = 1;
        int  held      = 0;
        int  first_c   = -1;
        int  done_c    = -1;
        int  ms_cnt    = 0;
        int  ms_bad    = 0;
        bit  obs       = 0;
        bit  done_seen = 0;
        exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;

        @(negedge clk);
        go = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        go = 1'b0;
        while (!done_seen && c < 300) begin
            if (mul_start) ms_cnt++;
            if (mul_start && (out_valid || !busy)) ms_bad++;
            go = inject_go && (c == 3 || c == 12 || c == 33);
            if (done) begin
                done_seen = 1;
                done_c    = c;
            end else if (out_valid) begin
                if (idx > 3) begin
                    check("extra_output", 1, 0);
                    out_ready = 1'b1;
                end else begin
                    if (!obs) begin
                        obs = 1;
                        if (first_c < 0) first_c = c;
                        check($sformatf("out%0d_data", idx), out_data, exp_v[idx]);
                        check($sformatf("out%0d_last", idx), out_last, (idx == 3));
                        held = 0;
                    end else begin
                        check($sformatf("out%0d_held", idx), out_data, exp_v[idx]);
                    end
                    if (idx == stall_idx && held < stall_n) begin
                        out_ready = 1'b0;
                        held++;
                    end else begin
                        out_ready = 1'b1;
                        idx++;
                        obs = 0;
                    end
                end
            end
            @(negedge clk);
            c++;
        end
        go = 1'b0;
        out_ready = 1'b1;
        check("done_seen", done_seen, 1);
        check("done_cycle", done_c, exp_done_c);
        check("n_outputs", idx, 4);
        check("mul_start_cycles", ms_cnt, 36);
        check("mul_start_outside_issue", ms_bad, 0);
        if (stall_idx < 0) check("first_valid_cycle", first_c, 11);
        // done must be a single-cycle pulse followed by idle.
        check_quiet("post_done");
        // No stray frame from go pulses seen while busy.
        repeat (15) begin
            @(negedge clk);
            if (out_valid || busy) ms_bad++;
        end
        check("idle_after_frame", ms_bad, 0);
    endtask

    initial begin
        rst       = 1'b1;
        go        = 1'b0;
        out_ready = 1'b1;
        load_mem(0, 1, 1, 0);
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;

        // All ones: each window sums nine 1*1 products.
        run_frame(9, 9, 9, 9, -1, 0, 0, 45);

        // Full-scale operands: 9 * 225 = 2025, needs 11 bits.
        load_mem(0, 15, 15, 0);
        run_frame(2025, 2025, 2025, 2025, -1, 0, 0, 45);

        // Centre tap picks pixel (oy+1)*4 + (ox+1).
        load_mem(1, 0, 0, 1);
        run_frame(5, 6, 9, 10, -1, 0, 0, 45);

        // Back-pressure on output 2 for 5 cycles.
        load_mem(0, 1, 1, 0);
        run_frame(9, 9, 9, 9, 1, 5, 0, 50);

        // Reset during MAC of output 3 (MAC spans negedges 23..31).
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (24) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        check("pre_reset_mul_start", mul_start, 1);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("mid_reset");
        rst = 1'b0;
        run_frame(9, 9, 9, 9, -1, 0, 0, 45);

        // go pulses while busy are ignored.
        load_mem(1, 0, 0, 1);
        run_frame(5, 6, 9, 10, -1, 0, 1, 45);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_conv_window_driver
